// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT ping-pong sample loader.
package fft_pkg;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_STREAM} rd_state_t;
  localparam int BITREV_W = 16;
  // Reverse the low `size` bits of value; upper bits of the result are zero.
  function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] value, input int size);
    logic [BITREV_W-1:0] r;
    r = {<<{value}};
    return r >> (BITREV_W - size);
  endfunction
endpackage

// File: rtl/sample_bank_ram.sv
// sample_bank_ram: simple dual-port RAM, one write port, one registered read port.
module sample_bank_ram #(
  parameter int DW = 18,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_pingpong_loader.sv
// fft_pingpong_loader: double-buffered sample capture feeding the FFT in natural or bit-reversed order.
module fft_pingpong_loader
  import fft_pkg::*;
#(
  parameter int BIT_WIDTH = 28,
  parameter int IN_WIDTH  = 9,
  parameter int N         = 32,
  parameter int SIZE      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_re,
  input  logic [IN_WIDTH-1:0]  in_im,
  output logic                 in_ready,
  input  logic                 bitrev_en,
  input  logic                 rd_start,
  output logic                 frame_avail,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_re,
  output logic [BIT_WIDTH-1:0] out_im,
  output logic [SIZE-1:0]      out_idx,
  output logic                 out_last,
  output logic                 overrun,
  output logic [15:0]          frame_cnt
);
  bank_state_t bank [2];
  bank_state_t bank_n [2];
  rd_state_t rd_state;
  logic wb, wb_n, rb, rb_n, rd_bank, brev;
  logic [SIZE-1:0] wcnt, ridx, raddr;
  logic [2*IN_WIDTH-1:0] rdata;
  logic wr_en, wr_last, rd_go, rd_done;

  assign wr_en   = in_valid && in_ready;
  assign wr_last = wr_en && wcnt == SIZE'(N-1);
  assign rd_go   = rd_start && frame_avail && rd_state == RD_IDLE;
  assign rd_done = rd_state == RD_STREAM && out_last;
  assign rb_n    = rd_go ? ~rb : rb;
  assign wb_n    = wr_last ? ~wb : wb;
  // Address one sample ahead of out_idx so the registered RAM read lines up with it.
  assign ridx    = rd_state == RD_STREAM ? out_idx + SIZE'(1) : '0;
  assign raddr   = brev ? SIZE'(bitrev(BITREV_W'(ridx), SIZE)) : ridx;
  assign out_re  = out_valid ? BIT_WIDTH'(signed'(rdata[2*IN_WIDTH-1:IN_WIDTH])) : '0;
  assign out_im  = out_valid ? BIT_WIDTH'(signed'(rdata[IN_WIDTH-1:0])) : '0;

  always_comb begin
    bank_n = bank;
    if (wr_en) bank_n[wb] = wr_last ? B_FULL : B_FILLING;
    if (rd_go) bank_n[rb] = B_READING;
    if (rd_done) bank_n[rd_bank] = B_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank        <= '{B_EMPTY, B_EMPTY};
      wb          <= 1'b0;
      rb          <= 1'b0;
      wcnt        <= '0;
      in_ready    <= 1'b1;
      frame_avail <= 1'b0;
      overrun     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      bank        <= bank_n;
      wb          <= wb_n;
      rb          <= rb_n;
      wcnt        <= wr_en ? wcnt + SIZE'(1) : wcnt;
      in_ready    <= bank_n[wb_n] inside {B_EMPTY, B_FILLING};
      frame_avail <= bank_n[rb_n] == B_FULL;
      overrun     <= in_valid && !in_ready;
      frame_cnt   <= wr_last ? frame_cnt + 16'd1 : frame_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= RD_IDLE;
      rd_bank   <= 1'b0;
      brev      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: if (rd_go) begin
          rd_state <= RD_ADDR;
          rd_bank  <= rb;
          brev     <= bitrev_en;
        end
        RD_ADDR: begin
          rd_state  <= RD_STREAM;
          out_valid <= 1'b1;
          out_idx   <= '0;
          out_last  <= N == 1;
        end
        RD_STREAM: if (out_last) begin
          rd_state  <= RD_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_idx   <= '0;
        end else begin
          out_idx  <= out_idx + SIZE'(1);
          out_last <= out_idx == SIZE'(N-2);
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  sample_bank_ram #(.DW(2*IN_WIDTH), .AW(SIZE+1)) u_ram (
    .clk(clk),
    .we(wr_en),
    .waddr({wb, wcnt}),
    .wdata({in_re, in_im}),
    .raddr({rd_bank, raddr}),
    .rdata(rdata)
  );
endmodule
